// File: rtl/bram_bist_pkg.sv
// Shared types and the test-pattern generator for the BRAM self-test engine.
package bram_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int PATTERN_W = 32;

    // Callers zero-extend address and seed to PATTERN_W and keep the low DW bits.
    function automatic logic [PATTERN_W-1:0] bist_pattern(
        input logic [PATTERN_W-1:0] addr,
        input logic [PATTERN_W-1:0] seed,
        input logic                 invert
    );
        logic [PATTERN_W-1:0] p;
        p = addr ^ seed;
        return invert ? ~p : p;
    endfunction

endpackage

// File: rtl/bram_bist_rising_edge_detector.sv
// One-cycle registered pulse on a 0->1 transition of a synchronous input.
module rising_edge_detector (
    input  logic clk,
    input  logic nreset,
    input  logic din,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= din;
            pulse <= din & ~prev;
        end
    end

endmodule

// File: rtl/bram_bist.sv
// BRAM self-test: fills memory through port A, reads it back through port B,
// and reports pass/fail, a saturating mismatch count and the first bad address.
module bram_bist
    import bram_bist_pkg::*;
#(
    parameter int                      P_DATA_WIDTH    = 16,
    parameter int                      P_ADDRESS_WIDTH = 10,
    parameter logic [P_DATA_WIDTH-1:0] P_SEED          = 16'h5A3C,
    parameter int                      P_COUNT_WIDTH   = 8
) (
    input  logic                       I_CLK,
    input  logic                       I_NRESET,
    input  logic                       I_START,
    input  logic                       I_INVERT,
    output logic [P_ADDRESS_WIDTH-1:0] O_ADDRESS_A,
    output logic [P_DATA_WIDTH-1:0]    O_DATA_A,
    output logic                       O_WRITE_ENABLE_A,
    output logic [P_ADDRESS_WIDTH-1:0] O_ADDRESS_B,
    output logic [P_DATA_WIDTH-1:0]    O_DATA_B,
    output logic                       O_WRITE_ENABLE_B,
    input  logic [P_DATA_WIDTH-1:0]    I_DATA_B,
    output logic                       O_BUSY,
    output logic                       O_DONE,
    output logic                       O_PASS,
    output logic [P_COUNT_WIDTH-1:0]   O_ERROR_COUNT,
    output logic [P_ADDRESS_WIDTH-1:0] O_FAIL_ADDRESS
);

    localparam int AW = P_ADDRESS_WIDTH;
    localparam int DW = P_DATA_WIDTH;
    localparam int CW = P_COUNT_WIDTH;

    state_t          state, state_nxt;
    logic [AW-1:0]   addr, addr_nxt;
    logic            inv;
    logic            start_pulse;
    logic            start_run;
    logic            last_addr;

    logic [PATTERN_W-1:0] pattern_full;
    logic [DW-1:0]        pattern;
    logic                 unused_pattern;

    logic            cmp_vld;
    logic [DW-1:0]   exp_q;
    logic [AW-1:0]   cmp_addr;
    logic            mismatch;
    logic [CW-1:0]   count;
    logic [AW-1:0]   fail_addr;

    rising_edge_detector u_start_edge (
        .clk    (I_CLK),
        .nreset (I_NRESET),
        .din    (I_START),
        .pulse  (start_pulse)
    );

    assign pattern_full   = bist_pattern(PATTERN_W'(addr), PATTERN_W'(P_SEED), inv);
    assign pattern        = pattern_full[DW-1:0];
    assign unused_pattern = ^pattern_full;
    assign last_addr      = &addr;

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state <= S_IDLE;
            addr  <= '0;
            inv   <= 1'b0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            if (start_run)
                inv <= I_INVERT;
        end
    end

    // Start edges are only honoured from IDLE or DONE; during a run they fall through.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        start_run = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_pulse) begin
                    state_nxt = S_WRITE;
                    addr_nxt  = '0;
                    start_run = 1'b1;
                end
            end
            S_WRITE: begin
                addr_nxt = addr + 1'b1;
                if (last_addr) begin
                    state_nxt = S_READ;
                    addr_nxt  = '0;
                end
            end
            S_READ: begin
                addr_nxt = addr + 1'b1;
                if (last_addr) begin
                    state_nxt = S_DRAIN;
                    addr_nxt  = '0;
                end
            end
            S_DRAIN: state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Expected word and its address travel one cycle behind the port-B address,
    // lining up with the BRAM's registered read data.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            cmp_vld  <= 1'b0;
            exp_q    <= '0;
            cmp_addr <= '0;
        end else begin
            cmp_vld  <= (state == S_READ);
            exp_q    <= pattern;
            cmp_addr <= addr;
        end
    end

    assign mismatch = cmp_vld && (I_DATA_B != exp_q);

    // The count never wraps, so count==0 marks the first mismatch of the run.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            count     <= '0;
            fail_addr <= '0;
        end else if (start_run) begin
            count     <= '0;
            fail_addr <= '0;
        end else if (mismatch) begin
            if (!(&count))
                count <= count + 1'b1;
            if (count == '0)
                fail_addr <= cmp_addr;
        end
    end

    assign O_WRITE_ENABLE_A = (state == S_WRITE);
    assign O_ADDRESS_A      = (state == S_WRITE) ? addr : '0;
    assign O_DATA_A         = (state == S_WRITE) ? pattern : '0;
    assign O_ADDRESS_B      = (state == S_READ) ? addr : '0;
    assign O_DATA_B         = '0;
    assign O_WRITE_ENABLE_B = 1'b0;
    assign O_BUSY           = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
    assign O_DONE           = (state == S_DONE);
    assign O_PASS           = (state == S_DONE) && (count == '0);
    assign O_ERROR_COUNT    = count;
    assign O_FAIL_ADDRESS   = fail_addr;

endmodule

// File: tb/tb_bram_bist.sv
// Directed bench: two BIST instances, each driving a behavioural 1-cycle-latency BRAM.
module tb_bram_bist;

    logic        clk;
    logic        grst_n;

    logic        start_a, invert_a;
    logic [3:0]  addr_a_a, addr_b_a;
    logic [15:0] data_a_a, data_b_a, rdata_a;
    logic        we_a_a, we_b_a;
    logic        busy_a, done_a, pass_a;
    logic [2:0]  count_a;
    logic [3:0]  fail_a;

    logic        start_b, invert_b;
    logic [3:0]  addr_a_b, addr_b_b;
    logic [15:0] data_a_b, data_b_b, rdata_b;
    logic        we_a_b, we_b_b;
    logic        busy_b, done_b, pass_b;
    logic [7:0]  count_b;
    logic [3:0]  fail_b;

    logic [15:0] mem_a [16];
    logic [15:0] mem_b [16];
    logic        fault_en, force_zero, mid_pulse;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bram_bist #(
        .P_DATA_WIDTH(16), .P_ADDRESS_WIDTH(4), .P_SEED(16'h5A3C), .P_COUNT_WIDTH(3)
    ) u_dut_a (
        .I_CLK(clk), .I_NRESET(grst_n), .I_START(start_a), .I_INVERT(invert_a),
        .O_ADDRESS_A(addr_a_a), .O_DATA_A(data_a_a), .O_WRITE_ENABLE_A(we_a_a),
        .O_ADDRESS_B(addr_b_a), .O_DATA_B(data_b_a), .O_WRITE_ENABLE_B(we_b_a),
        .I_DATA_B(rdata_a), .O_BUSY(busy_a), .O_DONE(done_a), .O_PASS(pass_a),
        .O_ERROR_COUNT(count_a), .O_FAIL_ADDRESS(fail_a)
    );

    bram_bist #(
        .P_DATA_WIDTH(16), .P_ADDRESS_WIDTH(4), .P_SEED(16'h0000), .P_COUNT_WIDTH(8)
    ) u_dut_b (
        .I_CLK(clk), .I_NRESET(grst_n), .I_START(start_b), .I_INVERT(invert_b),
        .O_ADDRESS_A(addr_a_b), .O_DATA_A(data_a_b), .O_WRITE_ENABLE_A(we_a_b),
        .O_ADDRESS_B(addr_b_b), .O_DATA_B(data_b_b), .O_WRITE_ENABLE_B(we_b_b),
        .I_DATA_B(rdata_b), .O_BUSY(busy_b), .O_DONE(done_b), .O_PASS(pass_b),
        .O_ERROR_COUNT(count_b), .O_FAIL_ADDRESS(fail_b)
    );

    always @(posedge clk) begin
        if (we_a_a) mem_a[addr_a_a] <= data_a_a;
        if (force_zero)
            rdata_a <= 16'h0000;
        else
            rdata_a <= mem_a[addr_b_a] ^ {15'b0, fault_en && (addr_b_a == 4'd5)};
    end

    always @(posedge clk) begin
        if (we_a_b) mem_b[addr_a_b] <= data_a_b;
        rdata_b <= mem_b[addr_b_b];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses start on the chosen instance; lat counts clocks from the sampling edge to DONE.
    task automatic run(input bit sel, output int lat, output logic d1);
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        lat = -1;
        d1  = 1'bx;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) d1 = sel ? (done_b | pass_b) : (done_a | pass_a);
            if (n == 2) begin start_a = 1'b0; start_b = 1'b0; end
            if (mid_pulse && n == 5)  invert_b = 1'b0;
            if (mid_pulse && n == 20) start_b  = 1'b1;
            if (mid_pulse && n == 22) start_b  = 1'b0;
            if (sel ? done_b : done_a) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int   lat;
        logic d1;
        bit   hit;
        grst_n = 1'b0;
        start_a = 1'b0; invert_a = 1'b0; start_b = 1'b0; invert_b = 1'b0;
        fault_en = 1'b0; force_zero = 1'b0; mid_pulse = 1'b0;
        repeat (2) @(negedge clk);

        chk("reset_busy", busy_a, 0);
        chk("reset_done_pass", {done_a, pass_a}, 0);
        chk("reset_count_fail", {count_a, fail_a}, 0);
        chk("reset_port_a", {we_a_a, addr_a_a, data_a_a}, 0);
        chk("reset_port_b", {we_b_a, addr_b_a, data_b_a}, 0);
        grst_n = 1'b1;

        run(0, lat, d1);
        chk("clean_latency", lat, 34);
        chk("clean_pass", pass_a, 1);
        chk("clean_count", count_a, 0);
        chk("clean_fail_addr", fail_a, 0);
        chk("clean_mem3", mem_a[3], 16'h5A3F);

        fault_en = 1'b1;
        run(0, lat, d1);
        fault_en = 1'b0;
        chk("fault_latency", lat, 34);
        chk("fault_count", count_a, 1);
        chk("fault_fail_addr", fail_a, 5);
        chk("fault_pass", pass_a, 0);

        force_zero = 1'b1;
        run(0, lat, d1);
        force_zero = 1'b0;
        chk("sat_count", count_a, 7);
        chk("sat_fail_addr", fail_a, 0);
        chk("sat_pass", pass_a, 0);

        @(negedge clk);
        start_a = 1'b1;
        hit = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (n == 2) start_a = 1'b0;
            if (we_a_a && addr_a_a == 4'd7) begin
                hit = 1'b1;
                break;
            end
        end
        start_a = 1'b0;
        chk("midreset_reached_addr7", hit, 1);
        grst_n = 1'b0;
        #1;
        chk("midreset_busy_done_pass", {busy_a, done_a, pass_a}, 0);
        chk("midreset_port_a", {we_a_a, addr_a_a, data_a_a}, 0);
        chk("midreset_port_b", {addr_b_a, count_a, fail_a}, 0);
        @(negedge clk);
        grst_n = 1'b1;
        run(0, lat, d1);
        chk("after_reset_latency", lat, 34);
        chk("after_reset_pass", pass_a, 1);

        invert_b = 1'b1;
        mid_pulse = 1'b1;
        run(1, lat, d1);
        mid_pulse = 1'b0;
        chk("invert_latency", lat, 34);
        chk("invert_pass", pass_b, 1);
        chk("invert_count", count_b, 0);
        chk("invert_mem3", mem_b[3], 16'hFFFC);

        run(0, lat, d1);
        chk("restart_cleared", d1, 0);
        chk("restart_latency", lat, 34);
        chk("restart_pass", pass_a, 1);
        chk("restart_count_fail", {count_a, fail_a}, 0);
        chk("restart_mem3", mem_a[3], 16'h5A3F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
